// File: rtl/riscv_regfile_mp_pkg.sv
// Shared constants and types for the multi-ported integer register file.
package riscv_regfile_mp_pkg;

   localparam int unsigned RF_REG_COUNT    = 32;
   localparam int unsigned RF_REG_WIDTH    = 32;
   localparam int unsigned RF_ADDR_W       = $clog2(RF_REG_COUNT);
   localparam int unsigned RF_MAX_RD_PORTS = 4;
   localparam int unsigned RF_MAX_WR_PORTS = 2;

   typedef logic [RF_REG_WIDTH-1:0] reg_word_t;
   typedef logic [RF_ADDR_W-1:0]    reg_idx_t;

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
// A register issued and written back in the same cycle stays pending (the newer producer wins).
module riscv_rf_scoreboard
   import riscv_regfile_mp_pkg::*;
#(
   parameter int unsigned REG_COUNT    = RF_REG_COUNT,
   parameter int unsigned ADDR_W       = $clog2(REG_COUNT),
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned NUM_WR_PORTS = 1,
   parameter int unsigned ZERO_REG     = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             iss_en_i,
   input  logic [ADDR_W-1:0]                iss_rd_i,
   input  logic [NUM_WR_PORTS-1:0]          wr_en_i,
   input  logic [NUM_WR_PORTS*ADDR_W-1:0]   wr_addr_i,
   input  logic [NUM_RD_PORTS*ADDR_W-1:0]   rd_addr_i,
   output logic [NUM_RD_PORTS-1:0]          busy_o
);

   localparam bit ZeroEn = (ZERO_REG != 0);

   logic [REG_COUNT-1:0] pending_q;
   logic [REG_COUNT-1:0] pending_d;
   logic [REG_COUNT-1:0] set_vec;
   logic [REG_COUNT-1:0] clr_vec;

   // Decode issue/write-back into set and clear masks; set applied after clear so it wins.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_en_i && !(ZeroEn && (iss_rd_i == '0))) begin
         set_vec[iss_rd_i] = 1'b1;
      end
      for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
         if (wr_en_i[w]) begin
            clr_vec[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
      pending_d = (pending_q & ~clr_vec) | set_vec;
   end

   // Pending vector register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // A write-back this cycle unblocks the reader because the bypass forwards the value.
   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gen_busy
      logic [ADDR_W-1:0] rd_addr;
      assign rd_addr   = rd_addr_i[p*ADDR_W +: ADDR_W];
      assign busy_o[p] = pending_q[rd_addr] && !clr_vec[rd_addr];
   end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-ported integer register file with same-cycle write-through bypass.
// Optional pending-write scoreboard enabled by defining REGFILE_SCOREBOARD_EN;
// without it busy_o is tied low and the iss_* inputs are ignored.
module riscv_regfile_mp
   import riscv_regfile_mp_pkg::*;
#(
   parameter int unsigned REG_COUNT    = RF_REG_COUNT,
   parameter int unsigned REG_WIDTH    = RF_REG_WIDTH,
   parameter int unsigned ADDR_W       = $clog2(REG_COUNT),
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned NUM_WR_PORTS = 1,
   parameter int unsigned ZERO_REG     = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_RD_PORTS*ADDR_W-1:0]    rd_addr_i,
   output logic [NUM_RD_PORTS*REG_WIDTH-1:0] rd_data_o,
   input  logic [NUM_WR_PORTS-1:0]           wr_en_i,
   input  logic [NUM_WR_PORTS*ADDR_W-1:0]    wr_addr_i,
   input  logic [NUM_WR_PORTS*REG_WIDTH-1:0] wr_data_i,
   input  logic                              iss_en_i,
   input  logic [ADDR_W-1:0]                 iss_rd_i,
   output logic [NUM_RD_PORTS-1:0]           busy_o
);

   localparam bit ZeroEn = (ZERO_REG != 0);

   logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
   logic [REG_WIDTH-1:0] regs_d [REG_COUNT];

   // Next array state; ports applied in ascending order so the highest index wins a conflict.
   always_comb begin
      for (int unsigned r = 0; r < REG_COUNT; r++) begin
         regs_d[r] = regs_q[r];
      end
      for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
         if (wr_en_i[w] && !(ZeroEn && (wr_addr_i[w*ADDR_W +: ADDR_W] == '0))) begin
            regs_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = wr_data_i[w*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

   // Storage array; reset discards any write presented in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < REG_COUNT; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < REG_COUNT; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gen_rd
      logic [ADDR_W-1:0]    rd_addr;
      logic [REG_WIDTH-1:0] rd_data;

      assign rd_addr = rd_addr_i[p*ADDR_W +: ADDR_W];

      // Array read with write-through bypass; forced to zero for x0 and while in reset.
      always_comb begin
         rd_data = regs_q[rd_addr];
         for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rd_addr)) begin
               rd_data = wr_data_i[w*REG_WIDTH +: REG_WIDTH];
            end
         end
         if (!rst_n || (ZeroEn && (rd_addr == '0))) begin
            rd_data = '0;
         end
      end

      assign rd_data_o[p*REG_WIDTH +: REG_WIDTH] = rd_data;
   end

`ifdef REGFILE_SCOREBOARD_EN
   riscv_rf_scoreboard #(
      .REG_COUNT    (REG_COUNT),
      .ADDR_W       (ADDR_W),
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .ZERO_REG     (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_en_i  (iss_en_i),
      .iss_rd_i  (iss_rd_i),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .rd_addr_i (rd_addr_i),
      .busy_o    (busy_o)
   );
`else
   logic unused_iss;
   assign unused_iss = ^{iss_en_i, iss_rd_i};
   assign busy_o     = '0;
`endif

endmodule
